periwinkle_core: RTL and testbench
==================================

# periwinkle_core

Parametrised successor of the Periwinkle transport-triggered core: executes one 40-bit move per cycle from an external program memory, with configurable data width, GPR count and data-memory depth. Adds a valid/ready ALU interface with stall, a halt SPR, post-incrementing dereference and zero-seed protection on the RNG. Sits between program ROM and the ALU at the top of the CPU.

## Interface
- DATA_W, 32: datapath width, 8..32; literals are instr[6+DATA_W-1:6].
- GPR_COUNT, 32: implemented GPRs, 1..32.
- DMEM_DEPTH, 64: data-memory words, power of two, ≤64; REF width is log2(DMEM_DEPTH).
- PMEM_AW, 8: program-address width.
- RNG_SEED, 32'h1: nonzero LFSR reset and reload value.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- o_pmem_addr  out  PMEM_AW  current PC.
- i_instr  in  40  instruction at o_pmem_addr, combinational read.
- o_alu_in_op  out  2  ALU input operation (dest SPR 4..7, low bits).
- o_alu_in_valid  out  1  operand offered.
- o_alu_in_data  out  DATA_W  operand.
- i_alu_in_ready  in  1  ALU accepts operand.
- o_alu_out_op  out  2  requested result selector.
- o_alu_out_ready  out  1  core consumes result.
- i_alu_out_valid  in  1  result available.
- i_alu_out_data  in  DATA_W  result.
- i_alu_out_flags  in  5  result flags.
- o_halted  out  1  core halted.

## Operation
- Decode: bit39 transfer (0 = literal source); bit38 ignored; [37:6] source; [5:0] dest. Operand bit5 = 1 selects GPR [4:0], else SPR [4:0]. GPR index ≥ GPR_COUNT reads 0, write ignored.
- SPR map: 0 PC, 1 STATUS (read-only), 2 HALT, 3 RNG, 4–7 ALU, 8 SIZ, 9 SINZ, 10 REF, 11 DEF, 12 NULL, 13 DEFI; others read 0, writes ignored.
- PC: write loads value mod 2^PMEM_AW; SIZ skips (PC+2) if value == 0, SINZ if value != 0, else PC+1; all PC arithmetic wraps.
- DEF: reads/writes dmem[REF]. DEFI: same access, then REF <= REF+1 mod DMEM_DEPTH; DEFI->DEFI increments once. An explicit REF write in the same move beats the increment.
- RNG: 32-bit Fibonacci LFSR, new MSB = ^(rng & 32'h800007D8), shift right; advances once per completed move reading RNG; reads return rng[DATA_W-1:0]. Write loads value zero-extended, RNG_SEED if zero. Write beats advance.
- STATUS: <= {zero, i_alu_out_flags} on every result handshake.
- HALT: nonzero write sets o_halted; PC frozen, no further effects until reset. Zero write is a no-op.
- Control FSM: RUN, STALL, HALTED. RUN/STALL complete the move when every ALU side it touches handshakes; otherwise STALL (no state, PC, memory, RNG or GPR change). Completion → RUN, or HALTED on HALT write.
- ALU handshake: o_alu_out_ready = src is ALU & (dest not ALU | i_alu_in_ready); o_alu_in_valid = dest is ALU & (src not ALU | i_alu_out_valid). ALU->ALU moves both sides in the same cycle. The ALU must not derive in_ready from out_ready.

## Timing
- Reset: PC 0, STATUS 0, REF 0, RNG RNG_SEED, GPRs 0, FSM RUN, o_halted 0. While reset is low, o_alu_in_valid = o_alu_out_ready = 0. Data memory is not reset.
- Non-ALU move: 1 cycle; all state updates on the completing edge.
- ALU move: 1 + stall cycles; zero added latency when valid/ready are already high.
- Reset mid-stall abandons the move; no partial update.
- In HALTED, both handshake outputs are 0.

## Configuration
- PERIWINKLE_RNG_EN defined: RNG SPR and LFSR present as above.
- Undefined: SPR 3 reads 0, writes ignored, no LFSR flops.

## Structure
- periwinkle_pkg: SPR indices, instruction field positions, ALU op encoding, LFSR tap mask, FSM state enum.
- Sub-module periwinkle_rng: LFSR with load, advance and seed-guard; instantiated only under PERIWINKLE_RNG_EN.

## Test plan
- Literal 0x1234 -> GPR 5, then GPR 5 -> DEF with REF = 3: dmem[3] = 0x1234, PC advances by 1 each cycle.
- SIZ with source 0 at PC 10 -> PC 12; SINZ with source 0 -> PC 11; PC jump to 2^PMEM_AW+4 lands on 4.
- GPR -> ALU SPR 4 with i_alu_in_ready low for 3 cycles -> PC holds 3 cycles, o_alu_in_valid high throughout, completes on ready.
- ALU SPR 5 -> ALU SPR 4, out_valid high but in_ready low -> o_alu_out_ready 0, STATUS unchanged; both rise → flags latched, data forwarded.
- Three DEFI reads from REF = DMEM_DEPTH-1 -> values dmem[63], dmem[0], dmem[1], REF ends at 2.
- RNG write 0 -> next read returns RNG_SEED; HALT write 1 -> o_halted high, PC frozen, deassert i_rst_n -> PC 0, o_halted 0.

Source files
------------

// File: rtl/periwinkle_pkg.sv
// Shared definitions for the Periwinkle transport-triggered core: move fields,
// SPR map, ALU op encoding, LFSR taps and control FSM states.
package periwinkle_pkg;

  localparam int INSTR_W  = 40;
  localparam int XFER_BIT = 39;
  localparam int SRC_LSB  = 6;
  localparam int OPND_W   = 6;

  typedef logic [4:0] spr_idx_t;

  localparam spr_idx_t SPR_PC       = 5'd0;
  localparam spr_idx_t SPR_STATUS   = 5'd1;
  localparam spr_idx_t SPR_HALT     = 5'd2;
  localparam spr_idx_t SPR_RNG      = 5'd3;
  localparam spr_idx_t SPR_ALU_BASE = 5'd4;
  localparam spr_idx_t SPR_SIZ      = 5'd8;
  localparam spr_idx_t SPR_SINZ     = 5'd9;
  localparam spr_idx_t SPR_REF      = 5'd10;
  localparam spr_idx_t SPR_DEF      = 5'd11;
  localparam spr_idx_t SPR_NULL     = 5'd12;
  localparam spr_idx_t SPR_DEFI     = 5'd13;

  typedef enum logic [1:0] {ALU_OP0, ALU_OP1, ALU_OP2, ALU_OP3} alu_op_e;

  localparam logic [31:0] LFSR_TAPS = 32'h800007D8;

  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_HALTED} state_e;

  typedef struct packed {
    logic              lit;
    logic [OPND_W-1:0] src;
    logic [OPND_W-1:0] dst;
  } move_t;

  function automatic logic is_spr(logic [OPND_W-1:0] opnd, spr_idx_t idx);
    return !opnd[5] && (opnd[4:0] == idx);
  endfunction

  // SPRs 4..7 all map onto the ALU; the low two bits carry the op
  function automatic logic is_alu(logic [OPND_W-1:0] opnd);
    return !opnd[5] && (opnd[4:2] == SPR_ALU_BASE[4:2]);
  endfunction

  function automatic alu_op_e alu_op(logic [OPND_W-1:0] opnd);
    return alu_op_e'(opnd[1:0]);
  endfunction

endpackage

// File: rtl/periwinkle_rng.sv
// 32-bit Fibonacci LFSR with load, advance and a guard that never lets the
// register be seeded with zero.
module periwinkle_rng
  import periwinkle_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_load_val,
  input  logic        i_adv,
  output logic [31:0] o_rng
);

  logic [31:0] rng_q;

  // a load wins over an advance in the same move
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    rng_q <= SEED;
    else if (i_load) rng_q <= (i_load_val == '0) ? SEED : i_load_val;
    else if (i_adv)  rng_q <= {^(rng_q & LFSR_TAPS), rng_q[31:1]};
  end

  assign o_rng = rng_q;

endmodule

// File: rtl/periwinkle_core.sv
// Periwinkle core: one 40-bit move per cycle with a valid/ready ALU port,
// stall/halt control, DEF/DEFI dereference and an optional RNG SPR
// (enabled by defining PERIWINKLE_RNG_EN).
module periwinkle_core
  import periwinkle_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          GPR_COUNT  = 32,
  parameter int          DMEM_DEPTH = 64,
  parameter int          PMEM_AW    = 8,
  parameter logic [31:0] RNG_SEED   = 32'h1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic [PMEM_AW-1:0] o_pmem_addr,
  input  logic [INSTR_W-1:0] i_instr,
  output logic [1:0]         o_alu_in_op,
  output logic               o_alu_in_valid,
  output logic [DATA_W-1:0]  o_alu_in_data,
  input  logic               i_alu_in_ready,
  output logic [1:0]         o_alu_out_op,
  output logic               o_alu_out_ready,
  input  logic               i_alu_out_valid,
  input  logic [DATA_W-1:0]  i_alu_out_data,
  input  logic [4:0]         i_alu_out_flags,
  output logic               o_halted
);

  localparam int RW = $clog2(DMEM_DEPTH);

  state_e             state_q, state_d;
  logic [PMEM_AW-1:0] pc_q, pc_d;
  logic [DATA_W-1:0]  status_q;
  logic [RW-1:0]      ref_q;
  logic [DATA_W-1:0]  gpr_q [32];
  logic [DATA_W-1:0]  dmem  [DMEM_DEPTH];

  move_t             mv;
  logic [DATA_W-1:0] src_val;
  logic              src_alu, dst_alu, running, done, halt_wr, defi_hit;
  logic              out_hs, in_hs;

  assign mv.lit = !i_instr[XFER_BIT];
  assign mv.src = i_instr[SRC_LSB +: OPND_W];
  assign mv.dst = i_instr[OPND_W-1:0];

  // a literal move has no source operand, so it can never touch ALU/RNG/DEFI
  assign src_alu  = !mv.lit && is_alu(mv.src);
  assign dst_alu  = is_alu(mv.dst);
  assign defi_hit = (!mv.lit && is_spr(mv.src, SPR_DEFI)) || is_spr(mv.dst, SPR_DEFI);

`ifdef PERIWINKLE_RNG_EN
  logic [31:0] rng_val;
  logic        unused_rng;

  periwinkle_rng #(.SEED(RNG_SEED)) u_rng (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (done && is_spr(mv.dst, SPR_RNG)),
    .i_load_val (32'(src_val)),
    .i_adv      (done && !mv.lit && is_spr(mv.src, SPR_RNG)),
    .o_rng      (rng_val)
  );
  assign unused_rng = ^rng_val;
`else
  logic unused_rng;
  assign unused_rng = ^RNG_SEED;
`endif

  logic unused_instr;
  assign unused_instr = ^i_instr[38:6];

  always_comb begin
    src_val = '0;
    if (mv.lit) begin
      src_val = i_instr[SRC_LSB +: DATA_W];
    end else if (mv.src[5]) begin
      if (int'(mv.src[4:0]) < GPR_COUNT) src_val = gpr_q[mv.src[4:0]];
    end else if (is_alu(mv.src)) begin
      src_val = i_alu_out_data;
    end else begin
      case (mv.src[4:0])
        SPR_PC:     src_val = DATA_W'(pc_q);
        SPR_STATUS: src_val = status_q;
        SPR_RNG: begin
`ifdef PERIWINKLE_RNG_EN
          src_val = rng_val[DATA_W-1:0];
`endif
        end
        SPR_REF:            src_val = DATA_W'(ref_q);
        SPR_DEF, SPR_DEFI:  src_val = dmem[ref_q];
        SPR_NULL:           src_val = '0;
        default:            src_val = '0;
      endcase
    end
  end

  // reset and halt both silence the handshake outputs
  assign running         = i_rst_n && (state_q != ST_HALTED);
  assign o_alu_out_ready = running && src_alu && (!dst_alu || i_alu_in_ready);
  assign o_alu_in_valid  = running && dst_alu && (!src_alu || i_alu_out_valid);
  assign out_hs          = o_alu_out_ready && i_alu_out_valid;
  assign in_hs           = o_alu_in_valid && i_alu_in_ready;
  assign done            = running && (!src_alu || out_hs) && (!dst_alu || in_hs);
  assign halt_wr         = is_spr(mv.dst, SPR_HALT) && (src_val != '0);

  assign o_alu_in_op   = alu_op(mv.dst);
  assign o_alu_out_op  = alu_op(mv.src);
  assign o_alu_in_data = src_val;
  assign o_pmem_addr   = pc_q;
  assign o_halted      = (state_q == ST_HALTED);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (done) state_d = halt_wr ? ST_HALTED : ST_RUN;
        else      state_d = ST_STALL;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pc_d = pc_q + PMEM_AW'(1);
    if (is_spr(mv.dst, SPR_PC))
      pc_d = PMEM_AW'(src_val);
    else if (is_spr(mv.dst, SPR_SIZ) && (src_val == '0))
      pc_d = pc_q + PMEM_AW'(2);
    else if (is_spr(mv.dst, SPR_SINZ) && (src_val != '0))
      pc_d = pc_q + PMEM_AW'(2);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      if (done) pc_q <= pc_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    status_q <= '0;
    else if (out_hs) status_q <= DATA_W'(i_alu_out_flags);
  end

  // explicit REF write beats the DEFI post-increment
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                             ref_q <= '0;
    else if (done && is_spr(mv.dst, SPR_REF)) ref_q <= src_val[RW-1:0];
    else if (done && defi_hit)                ref_q <= ref_q + RW'(1);
  end

  // unimplemented GPRs stay at their reset value and fold away
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int g = 0; g < 32; g++) gpr_q[g] <= '0;
    end else if (done && mv.dst[5] && (int'(mv.dst[4:0]) < GPR_COUNT)) begin
      gpr_q[mv.dst[4:0]] <= src_val;
    end
  end

  always_ff @(posedge i_clk) begin
    if (done && (is_spr(mv.dst, SPR_DEF) || is_spr(mv.dst, SPR_DEFI)))
      dmem[ref_q] <= src_val;
  end

endmodule

// File: tb/tb_periwinkle_core.sv
// Directed bench for periwinkle_core: a table of single-cycle moves with
// hand-computed results, then stall, ALU->ALU, halt and reset sequences.
module tb_periwinkle_core;

  localparam logic [31:0] SEED = 32'hACE10001;
`ifdef PERIWINKLE_RNG_EN
  localparam logic [31:0] RNG0 = SEED;
  localparam logic [31:0] RNG1 = 32'hD6708000;
  localparam logic [31:0] RNG2 = 32'h5;
`else
  localparam logic [31:0] RNG0 = 32'h0;
  localparam logic [31:0] RNG1 = 32'h0;
  localparam logic [31:0] RNG2 = 32'h0;
`endif

  logic        i_clk, i_rst_n;
  logic [7:0]  o_pmem_addr;
  logic [39:0] i_instr;
  logic [1:0]  o_alu_in_op, o_alu_out_op;
  logic        o_alu_in_valid, i_alu_in_ready, o_alu_out_ready, i_alu_out_valid;
  logic [31:0] o_alu_in_data, i_alu_out_data;
  logic [4:0]  i_alu_out_flags;
  logic        o_halted;

  periwinkle_core #(
    .DATA_W(32), .GPR_COUNT(16), .DMEM_DEPTH(64), .PMEM_AW(8), .RNG_SEED(SEED)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .o_pmem_addr(o_pmem_addr), .i_instr(i_instr),
    .o_alu_in_op(o_alu_in_op), .o_alu_in_valid(o_alu_in_valid),
    .o_alu_in_data(o_alu_in_data), .i_alu_in_ready(i_alu_in_ready),
    .o_alu_out_op(o_alu_out_op), .o_alu_out_ready(o_alu_out_ready),
    .i_alu_out_valid(i_alu_out_valid), .i_alu_out_data(i_alu_out_data),
    .i_alu_out_flags(i_alu_out_flags), .o_halted(o_halted)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  typedef struct {
    logic [39:0] instr;
    logic        rdy;
    logic [7:0]  pc;
    logic        iv;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0, n_total = 0;

  function automatic logic [5:0] G(int n); return {1'b1, 5'(n)}; endfunction
  function automatic logic [5:0] S(int n); return {1'b0, 5'(n)}; endfunction
  function automatic logic [39:0] mv(logic [5:0] s, logic [5:0] d);
    return {2'b10, 26'd0, s, d};
  endfunction
  function automatic logic [39:0] lit(logic [31:0] v, logic [5:0] d);
    return {2'b00, v, d};
  endfunction

  task automatic add(logic [39:0] ins, logic rdy, logic [7:0] pc, logic iv, logic [31:0] d);
    vec_t v;
    v.instr = ins; v.rdy = rdy; v.pc = pc; v.iv = iv; v.data = d;
    tbl.push_back(v);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(logic [39:0] ins, logic rdy, logic ov, logic [31:0] od, logic [4:0] fl);
    i_instr = ins; i_alu_in_ready = rdy; i_alu_out_valid = ov;
    i_alu_out_data = od; i_alu_out_flags = fl;
  endtask

  task automatic edge_step();
    @(posedge i_clk); #1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    drive(mv(S(5), S(4)), 1'b1, 1'b1, 32'h0, 5'h0);
    #2;
    chk("rst_pc", o_pmem_addr, 8'd0);
    chk("rst_halted", o_halted, 1'b0);
    chk("rst_in_valid", o_alu_in_valid, 1'b0);
    chk("rst_out_ready", o_alu_out_ready, 1'b0);
    edge_step();
    i_rst_n = 1'b1;

    add(lit(32'h1234, G(5)),  0, 8'd0,  0, 0);
    add(lit(32'd3, S(10)),    0, 8'd1,  0, 0);
    add(mv(G(5), S(11)),      0, 8'd2,  0, 0);
    add(mv(S(11), S(4)),      1, 8'd3,  1, 32'h1234);
    add(lit(32'd10, S(0)),    0, 8'd4,  0, 0);
    add(lit(32'd0, S(8)),     0, 8'd10, 0, 0);
    add(lit(32'd0, S(9)),     0, 8'd12, 0, 0);
    add(lit(32'd5, S(9)),     0, 8'd13, 0, 0);
    add(lit(32'd7, S(8)),     0, 8'd15, 0, 0);
    add(lit(32'h104, S(0)),   0, 8'd16, 0, 0);
    add(mv(S(0), S(4)),       1, 8'd4,  1, 32'd4);
    add(lit(32'hAB, G(20)),   0, 8'd5,  0, 0);
    add(mv(G(20), S(4)),      1, 8'd6,  1, 32'd0);
    add(mv(G(5), S(6)),       1, 8'd7,  1, 32'h1234);
    add(lit(32'd63, S(10)),   0, 8'd8,  0, 0);
    add(lit(32'h11, S(11)),   0, 8'd9,  0, 0);
    add(lit(32'd0, S(10)),    0, 8'd10, 0, 0);
    add(lit(32'h22, S(11)),   0, 8'd11, 0, 0);
    add(lit(32'd1, S(10)),    0, 8'd12, 0, 0);
    add(lit(32'h33, S(11)),   0, 8'd13, 0, 0);
    add(lit(32'd63, S(10)),   0, 8'd14, 0, 0);
    add(mv(S(13), S(4)),      1, 8'd15, 1, 32'h11);
    add(mv(S(13), S(4)),      1, 8'd16, 1, 32'h22);
    add(mv(S(13), S(4)),      1, 8'd17, 1, 32'h33);
    add(mv(S(10), S(4)),      1, 8'd18, 1, 32'd2);
    add(lit(32'd1, S(10)),    0, 8'd19, 0, 0);
    add(mv(S(13), S(10)),     0, 8'd20, 0, 0);
    add(mv(S(10), S(4)),      1, 8'd21, 1, 32'h33);
    add(lit(32'd0, S(3)),     0, 8'd22, 0, 0);
    add(mv(S(3), S(4)),       1, 8'd23, 1, RNG0);
    add(mv(S(3), S(4)),       1, 8'd24, 1, RNG1);
    add(lit(32'd5, S(3)),     0, 8'd25, 0, 0);
    add(mv(S(3), S(4)),       1, 8'd26, 1, RNG2);
    add(lit(32'd0, S(2)),     0, 8'd27, 0, 0);
    add(mv(S(1), S(4)),       1, 8'd28, 1, 32'd0);

    foreach (tbl[i]) begin
      drive(tbl[i].instr, tbl[i].rdy, 1'b0, 32'h0, 5'h0);
      #2;
      chk($sformatf("v%0d_pc", i), o_pmem_addr, tbl[i].pc);
      chk($sformatf("v%0d_in_valid", i), o_alu_in_valid, tbl[i].iv);
      chk($sformatf("v%0d_halted", i), o_halted, 1'b0);
      if (tbl[i].iv) chk($sformatf("v%0d_data", i), o_alu_in_data, tbl[i].data);
      edge_step();
    end

    // ALU input stall: ready low for three cycles
    drive(mv(G(5), S(4)), 1'b0, 1'b0, 32'h0, 5'h0);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("stall%0d_pc", c), o_pmem_addr, 8'd29);
      chk($sformatf("stall%0d_in_valid", c), o_alu_in_valid, 1'b1);
      edge_step();
    end
    i_alu_in_ready = 1'b1;
    #2;
    chk("stall_done_data", o_alu_in_data, 32'h1234);
    edge_step();
    chk("stall_done_pc", o_pmem_addr, 8'd30);

    // ALU->ALU with consumer not ready: no handshake, STATUS untouched
    drive(mv(S(5), S(4)), 1'b0, 1'b1, 32'hBEEF, 5'h1F);
    for (int c = 0; c < 2; c++) begin
      #2;
      chk($sformatf("a2a_stall%0d_out_ready", c), o_alu_out_ready, 1'b0);
      chk($sformatf("a2a_stall%0d_in_valid", c), o_alu_in_valid, 1'b1);
      chk($sformatf("a2a_stall%0d_pc", c), o_pmem_addr, 8'd30);
      edge_step();
    end
    drive(mv(S(1), S(4)), 1'b1, 1'b0, 32'h0, 5'h0);
    #2;
    chk("status_unchanged", o_alu_in_data, 32'd0);
    edge_step();
    drive(mv(S(5), S(4)), 1'b1, 1'b1, 32'hDEAD, 5'h15);
    #2;
    chk("a2a_out_ready", o_alu_out_ready, 1'b1);
    chk("a2a_fwd_data", o_alu_in_data, 32'hDEAD);
    chk("a2a_out_op", o_alu_out_op, 2'd1);
    chk("a2a_in_op", o_alu_in_op, 2'd0);
    edge_step();
    chk("a2a_pc", o_pmem_addr, 8'd32);
    drive(mv(S(1), S(4)), 1'b1, 1'b0, 32'h0, 5'h0);
    #2;
    chk("status_flags", o_alu_in_data, 32'h15);
    edge_step();

    // halt: PC frozen, handshake outputs silenced
    drive(lit(32'd1, S(2)), 1'b0, 1'b0, 32'h0, 5'h0);
    edge_step();
    drive(mv(S(5), S(4)), 1'b1, 1'b1, 32'h0, 5'h0);
    for (int c = 0; c < 2; c++) begin
      #2;
      chk($sformatf("halt%0d_halted", c), o_halted, 1'b1);
      chk($sformatf("halt%0d_pc", c), o_pmem_addr, 8'd34);
      chk($sformatf("halt%0d_in_valid", c), o_alu_in_valid, 1'b0);
      chk($sformatf("halt%0d_out_ready", c), o_alu_out_ready, 1'b0);
      edge_step();
    end

    i_rst_n = 1'b0;
    #2;
    chk("rst2_pc", o_pmem_addr, 8'd0);
    chk("rst2_halted", o_halted, 1'b0);
    edge_step();
    i_rst_n = 1'b1;
    drive(lit(32'd9, G(5)), 1'b0, 1'b0, 32'h0, 5'h0);
    edge_step();

    // reset in the middle of a stall abandons the move
    drive(mv(G(5), S(4)), 1'b0, 1'b0, 32'h0, 5'h0);
    edge_step();
    #2;
    chk("midstall_pc", o_pmem_addr, 8'd1);
    chk("midstall_data", o_alu_in_data, 32'd9);
    i_rst_n = 1'b0;
    #1;
    chk("midstall_rst_pc", o_pmem_addr, 8'd0);
    chk("midstall_rst_in_valid", o_alu_in_valid, 1'b0);
    edge_step();
    i_rst_n = 1'b1;
    i_alu_in_ready = 1'b1;
    #2;
    chk("post_rst_gpr", o_alu_in_data, 32'd0);
    edge_step();
    chk("post_rst_pc", o_pmem_addr, 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
